// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-port round-robin write-back arbiter for the integer register file
//
// Two requesters share the register file's single write port:
//   port 0 is the ALU result, port 1 is the load result.
// Each port has a valid/ready handshake in front of a one-entry holding buffer.
// A round-robin arbiter drains the buffers into registered rf_we/rf_waddr/rf_wdata.
// Writes to x0 are consumed and dropped.
// flush squashes all buffered writes.
// wr_count counts the rf_we pulses that have been issued.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   flush               synchronous squash of pending writes, blocks accepts
//   reqN_valid/ready    handshake for requester N (0 = ALU, 1 = load)
//   reqN_addr/data      destination register and write data for requester N
//   rf_we/waddr/wdata   registered register-file write port
//   busy                at least one holding buffer is occupied
//   wr_count            issued writes since reset, wraps modulo 2^CNT_LEN

module regfile_wb_arbiter #(
    parameter int DATA_LEN     = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int CNT_LEN      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [REG_ADDR_LEN-1:0] req0_addr,
    input  logic [DATA_LEN-1:0]     req0_data,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [REG_ADDR_LEN-1:0] req1_addr,
    input  logic [DATA_LEN-1:0]     req1_data,
    output logic                    rf_we,
    output logic [REG_ADDR_LEN-1:0] rf_waddr,
    output logic [DATA_LEN-1:0]     rf_wdata,
    output logic                    busy,
    output logic [CNT_LEN-1:0]      wr_count
);

    logic [1:0]              buf_valid_q, buf_valid_d;
    logic [REG_ADDR_LEN-1:0] buf_addr_q [2];
    logic [REG_ADDR_LEN-1:0] buf_addr_d [2];
    logic [DATA_LEN-1:0]     buf_data_q [2];
    logic [DATA_LEN-1:0]     buf_data_d [2];
    logic                    rr_q, rr_d;
    logic                    rf_we_q, rf_we_d;
    logic [REG_ADDR_LEN-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_LEN-1:0]     rf_wdata_q, rf_wdata_d;
    logic [CNT_LEN-1:0]      wr_count_q, wr_count_d;

    logic [1:0]              grant;
    logic [1:0]              ready;
    logic [1:0]              accept;
    logic [1:0]              req_valid;
    logic [REG_ADDR_LEN-1:0] req_addr [2];
    logic [DATA_LEN-1:0]     req_data [2];

    assign req_valid   = {req1_valid, req0_valid};
    assign req_addr[0] = req0_addr;
    assign req_addr[1] = req1_addr;
    assign req_data[0] = req0_data;
    assign req_data[1] = req1_data;

    // Round-robin only matters when both buffers are occupied; a lone
    // occupant always wins. Nothing is granted while flushing.
    always_comb begin
        grant = 2'b00;
        if (!flush) begin
            if (buf_valid_q == 2'b11) begin
                grant[rr_q] = 1'b1;
            end else begin
                grant = buf_valid_q;
            end
        end
    end

    // A buffer being drained this cycle can be refilled on the same edge,
    // which is what lets a lone requester sustain one write per cycle.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ready[i] = !flush && (!buf_valid_q[i] || grant[i]);
        end
    end

    assign accept     = req_valid & ready;
    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        rr_d        = rr_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        wr_count_d  = wr_count_q;
        if (flush) begin
            buf_valid_d = 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    rf_we_d        = 1'b1;
                    rf_waddr_d     = buf_addr_q[i];
                    rf_wdata_d     = buf_data_q[i];
                    buf_valid_d[i] = 1'b0;
                    rr_d           = (i == 0);
                    wr_count_d     = wr_count_q + 1'b1;
                end
            end
            // Accepts are applied after grant clearing so a same-edge refill wins.
            // x0 requests are handshaken but never buffered.
            for (int i = 0; i < 2; i++) begin
                if (accept[i] && (req_addr[i] != '0)) begin
                    buf_valid_d[i] = 1'b1;
                    buf_addr_d[i]  = req_addr[i];
                    buf_data_d[i]  = req_data[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 2'b00;
            rr_q        <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            wr_count_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            rr_q        <= rr_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            wr_count_q  <= wr_count_d;
        end
    end

    // Buffer payload is qualified by buf_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        buf_addr_q <= buf_addr_d;
        buf_data_q <= buf_data_d;
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = |buf_valid_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter

module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;
    logic [3:0]  wr_count;

    regfile_wb_arbiter #(
        .DATA_LEN    (32),
        .REG_ADDR_LEN(5),
        .CNT_LEN     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_addr (req0_addr),
        .req0_data (req0_data),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_addr (req1_addr),
        .req1_data (req1_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .busy      (busy),
        .wr_count  (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file driven by the DUT write port.
    logic [31:0] tb_rf [32];
    always @(posedge clk) begin
        if (rf_we) tb_rf[rf_waddr] <= rf_wdata;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f,
                         input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        rst        = r;
        flush      = f;
        req0_valid = v0;
        req0_addr  = a0;
        req0_data  = d0;
        req1_valid = v1;
        req1_addr  = a1;
        req1_data  = d1;
    endtask

    typedef struct {
        logic        rst, flush;
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        chk_rdy, r0, r1;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [3:0]  cnt;
        logic        bsy;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic f,
                                input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                                input logic cr, input logic r0, input logic r1,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [3:0] cnt, input logic bsy);
        vec_t v;
        v.rst = r; v.flush = f;
        v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.chk_rdy = cr; v.r0 = r0; v.r1 = r1;
        v.we = we; v.wa = wa; v.wd = wd; v.cnt = cnt; v.bsy = bsy;
        return v;
    endfunction

    // Reference model: each port owns at most one pending write, service
    // alternates between ports when both are pending, and a write becomes
    // visible on the port one edge after it is picked.
    bit          m_pend  [2];
    logic [4:0]  m_paddr [2];
    logic [31:0] m_pdata [2];
    int          m_turn;
    bit          m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    int          m_cnt;
    logic [31:0] m_rf      [32];
    bit          m_written [32];

    function automatic int m_pick();
        if (flush) return -1;
        if (m_pend[0] && m_pend[1]) return m_turn;
        if (m_pend[0]) return 0;
        if (m_pend[1]) return 1;
        return -1;
    endfunction

    function automatic bit m_ready(input int p);
        return !flush && (!m_pend[p] || m_pick() == p);
    endfunction

    task automatic model_edge();
        int   w;
        bit   rd [2];
        logic v  [2];
        logic [4:0]  a [2];
        logic [31:0] d [2];
        if (m_we) begin
            m_rf[m_wa]      = m_wd;
            m_written[m_wa] = 1'b1;
        end
        if (rst) begin
            m_pend[0] = 0; m_pend[1] = 0;
            m_turn = 0; m_we = 0; m_wa = '0; m_wd = '0; m_cnt = 0;
        end else if (flush) begin
            m_pend[0] = 0; m_pend[1] = 0;
            m_we = 0;
        end else begin
            w = m_pick();
            rd[0] = m_ready(0); rd[1] = m_ready(1);
            v[0] = req0_valid; a[0] = req0_addr; d[0] = req0_data;
            v[1] = req1_valid; a[1] = req1_addr; d[1] = req1_data;
            if (w >= 0) begin
                m_we = 1; m_wa = m_paddr[w]; m_wd = m_pdata[w];
                m_pend[w] = 0;
                m_turn = 1 - w;
                m_cnt = (m_cnt + 1) % 16;
            end else begin
                m_we = 0;
            end
            for (int p = 0; p < 2; p++) begin
                if (v[p] && rd[p] && a[p] != 0) begin
                    m_pend[p] = 1; m_paddr[p] = a[p]; m_pdata[p] = d[p];
                end
            end
        end
    endtask

    vec_t tbl[$];

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int r = 0; r < 32; r++) begin
            m_rf[r] = '0;
            m_written[r] = 0;
        end
        m_pend[0] = 0; m_pend[1] = 0; m_turn = 0; m_we = 0; m_wa = '0; m_wd = '0; m_cnt = 0;

        //               rst fl v0 a0  d0            v1 a1  d1            cr r0 r1 we wa  wd            cnt bsy
        tbl.push_back(mk(1, 0, 1, 5,  32'h1,        0, 0,  0,            0, 0, 0, 0, 0,  0,            0, 0));
        tbl.push_back(mk(1, 0, 1, 5,  32'h1,        0, 0,  0,            1, 1, 1, 0, 0,  0,            0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0,            0, 0,  0,            1, 1, 1, 0, 0,  0,            0, 0));
        tbl.push_back(mk(0, 0, 1, 5,  32'hDEADBEEF, 0, 0,  0,            1, 1, 1, 0, 0,  0,            0, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0,            0, 0,  0,            1, 1, 1, 1, 5,  32'hDEADBEEF, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0,            0, 0,  0,            1, 1, 1, 0, 5,  32'hDEADBEEF, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  0,            0, 0,  0,            1, 1, 1, 0, 0,  0,            0, 0));
        tbl.push_back(mk(0, 0, 1, 1,  32'h11,       1, 2,  32'h22,       1, 1, 1, 0, 0,  0,            0, 1));
        tbl.push_back(mk(0, 0, 1, 1,  32'h11,       1, 2,  32'h22,       1, 1, 0, 1, 1,  32'h11,       1, 1));
        tbl.push_back(mk(0, 0, 1, 1,  32'h11,       1, 2,  32'h22,       1, 0, 1, 1, 2,  32'h22,       2, 1));
        tbl.push_back(mk(0, 0, 1, 1,  32'h11,       1, 2,  32'h22,       1, 1, 0, 1, 1,  32'h11,       3, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0,            0, 0,  0,            1, 0, 1, 1, 2,  32'h22,       4, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0,            0, 0,  0,            1, 1, 1, 1, 1,  32'h11,       5, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0,            0, 0,  0,            1, 1, 1, 0, 1,  32'h11,       5, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0,            1, 0,  32'hFFFFFFFF, 1, 1, 1, 0, 1,  32'h11,       5, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0,            0, 0,  0,            1, 1, 1, 0, 1,  32'h11,       5, 0));
        tbl.push_back(mk(0, 0, 1, 7,  32'h77,       1, 8,  32'h88,       1, 1, 1, 0, 1,  32'h11,       5, 1));
        tbl.push_back(mk(0, 1, 1, 9,  32'h99,       1, 10, 32'hAA,       1, 0, 0, 0, 1,  32'h11,       5, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0,            0, 0,  0,            1, 1, 1, 0, 1,  32'h11,       5, 0));
        tbl.push_back(mk(0, 0, 1, 4,  32'h44,       0, 0,  0,            1, 1, 1, 0, 1,  32'h11,       5, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0,            0, 0,  0,            1, 1, 1, 1, 4,  32'h44,       6, 0));
        tbl.push_back(mk(0, 1, 0, 0,  0,            1, 6,  32'h66,       1, 0, 0, 0, 4,  32'h44,       6, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].flush, tbl[i].v0, tbl[i].a0, tbl[i].d0,
                  tbl[i].v1, tbl[i].a1, tbl[i].d1);
            #1;
            if (tbl[i].chk_rdy) begin
                chk($sformatf("row%0d_ready0", i), 32'(req0_ready), 32'(tbl[i].r0));
                chk($sformatf("row%0d_ready1", i), 32'(req1_ready), 32'(tbl[i].r1));
            end
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_we", i),       32'(rf_we),    32'(tbl[i].we));
            chk($sformatf("row%0d_waddr", i),    32'(rf_waddr), 32'(tbl[i].wa));
            chk($sformatf("row%0d_wdata", i),    rf_wdata,      tbl[i].wd);
            chk($sformatf("row%0d_wr_count", i), 32'(wr_count), 32'(tbl[i].cnt));
            chk($sformatf("row%0d_busy", i),     32'(busy),     32'(tbl[i].bsy));
        end
        chk("rf_x5",  tb_rf[5], 32'hDEADBEEF);
        chk("rf_x1",  tb_rf[1], 32'h11);
        chk("rf_x2",  tb_rf[2], 32'h22);
        chk("rf_x4_write_during_flush", tb_rf[4], 32'h44);

        // Counter wrap: 17 back-to-back writes from a lone requester.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 17; k++) begin
            drive(0, 0, 1, 3, 32'h300 + 32'(k), 0, 0, 0);
            #1;
            chk($sformatf("wrap_ready0_%0d", k), 32'(req0_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("wrap_last_we", 32'(rf_we), 32'd1);
        @(posedge clk);
        #1;
        chk("wrap_count", 32'(wr_count), 32'd1);
        chk("wrap_waddr", 32'(rf_waddr), 32'd3);
        chk("wrap_wdata", rf_wdata, 32'h310);
        chk("wrap_we_idle", 32'(rf_we), 32'd0);

        // Randomised traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            logic r, f;
            r = (c == 0) || ($urandom_range(63) == 0);
            f = ($urandom_range(9) == 0);
            drive(r, f,
                  1'($urandom_range(1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(1)), 5'($urandom_range(0, 7)), $urandom);
            #1;
            if (c != 0) begin
                chk($sformatf("rnd%0d_ready0", c), 32'(req0_ready), 32'(m_ready(0)));
                chk($sformatf("rnd%0d_ready1", c), 32'(req1_ready), 32'(m_ready(1)));
            end
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("rnd%0d_we", c),       32'(rf_we),    32'(m_we));
            if (m_we) begin
                chk($sformatf("rnd%0d_waddr", c), 32'(rf_waddr), 32'(m_wa));
                chk($sformatf("rnd%0d_wdata", c), rf_wdata,      m_wd);
            end
            chk($sformatf("rnd%0d_wr_count", c), 32'(wr_count), 32'(m_cnt));
            chk($sformatf("rnd%0d_busy", c),     32'(busy),     32'(m_pend[0] || m_pend[1]));
            chk($sformatf("rnd%0d_we_x0", c),    32'(rf_we && rf_waddr == 5'd0), 32'd0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            model_edge();
        end
        #1;
        for (int r = 1; r < 32; r++) begin
            if (m_written[r]) chk($sformatf("rnd_rf_x%0d", r), tb_rf[r], m_rf[r]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
